// File: rtl/vga_rx_if.sv
// vga_rx_if: VGA timing/pixel inputs and recovered frame outputs of vga_rx.
interface vga_rx_if;
    logic        hsync, vsync, vid_active;
    logic [7:0]  pix_R, pix_G, pix_B;
    logic        out_valid;
    logic [11:0] out_x, out_y;
    logic [7:0]  out_R, out_G, out_B;
    logic        frame_start;
    logic [11:0] h_total, h_active, v_total, v_active;
    logic [23:0] frame_sum;
    logic        locked, timing_err;
    modport slave (
        input  hsync, vsync, vid_active, pix_R, pix_G, pix_B,
        output out_valid, out_x, out_y, out_R, out_G, out_B, frame_start,
               h_total, h_active, v_total, v_active, frame_sum, locked, timing_err
    );
    modport master (
        output hsync, vsync, vid_active, pix_R, pix_G, pix_B,
        input  out_valid, out_x, out_y, out_R, out_G, out_B, frame_start,
               h_total, h_active, v_total, v_active, frame_sum, locked, timing_err
    );
endinterface

// File: rtl/vga_rx.sv
// vga_rx: recovers pixel coordinates, frame timing, checksum and lock status from a VGA stream.
module vga_rx #(
    parameter bit HS_ACTIVE   = 1'b0,
    parameter bit VS_ACTIVE   = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input logic     pix_clk,
    input logic     rst,
    vga_rx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, LOCKED} state_t;
    function automatic logic [11:0] inc12(input logic [11:0] x);
        return (x == 12'hfff) ? x : x + 12'd1;
    endfunction
    logic        hs1_q, vs1_q, act1_q, hs2_q, vs2_q;
    logic [7:0]  r1_q, g1_q, b1_q;
    logic [11:0] lc_q, line_len_q, ac_q, yc_q, vt_q, vact_q, ha_q;
    logic [23:0] sum_q, frame_sum_q;
    logic        out_valid_q, frame_start_q;
    logic [11:0] out_x_q, out_y_q, h_total_q, h_active_q, v_total_q, v_active_q;
    logic [7:0]  out_r_q, out_g_q, out_b_q;
    state_t      state_q, state_d;
    logic [3:0]  mc_q, mc_d;
    logic [47:0] ref_q, ref_d, meas;
    logic        te_q, te_d, hs_edge, vs_edge, line_act, match;

    assign hs_edge  = (hs1_q == HS_ACTIVE) && (hs2_q != HS_ACTIVE);
    assign vs_edge  = (vs1_q == VS_ACTIVE) && (vs2_q != VS_ACTIVE);
    assign line_act = hs_edge && (ac_q != 12'd0);
    assign meas     = {line_len_q, ha_q, vt_q, vact_q};
    // A frame without any hsync can never count as a good measurement.
    assign match    = (meas == ref_q) && (vt_q != 12'd0);

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            hs1_q  <= !HS_ACTIVE;
            hs2_q  <= !HS_ACTIVE;
            vs1_q  <= !VS_ACTIVE;
            vs2_q  <= !VS_ACTIVE;
            act1_q <= 1'b0;
            r1_q   <= 8'd0;
            g1_q   <= 8'd0;
            b1_q   <= 8'd0;
        end else begin
            hs1_q  <= bus.hsync;
            hs2_q  <= hs1_q;
            vs1_q  <= bus.vsync;
            vs2_q  <= vs1_q;
            act1_q <= bus.vid_active;
            r1_q   <= bus.pix_R;
            g1_q   <= bus.pix_G;
            b1_q   <= bus.pix_B;
        end
    end

    // On a coincident vsync/hsync, the hsync opens line 1 of the new frame.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            lc_q          <= 12'd0;
            line_len_q    <= 12'd0;
            ac_q          <= 12'd0;
            yc_q          <= 12'd0;
            vt_q          <= 12'd0;
            vact_q        <= 12'd0;
            ha_q          <= 12'd0;
            sum_q         <= 24'd0;
            out_valid_q   <= 1'b0;
            out_x_q       <= 12'd0;
            out_y_q       <= 12'd0;
            out_r_q       <= 8'd0;
            out_g_q       <= 8'd0;
            out_b_q       <= 8'd0;
            frame_start_q <= 1'b0;
            h_total_q     <= 12'd0;
            h_active_q    <= 12'd0;
            v_total_q     <= 12'd0;
            v_active_q    <= 12'd0;
            frame_sum_q   <= 24'd0;
        end else begin
            lc_q          <= hs_edge ? 12'd0 : inc12(lc_q);
            line_len_q    <= hs_edge ? inc12(lc_q) : line_len_q;
            ac_q          <= hs_edge ? 12'd0 : (act1_q ? inc12(ac_q) : ac_q);
            yc_q          <= vs_edge ? {11'd0, line_act} : (line_act ? inc12(yc_q) : yc_q);
            vt_q          <= vs_edge ? {11'd0, hs_edge} : (hs_edge ? inc12(vt_q) : vt_q);
            vact_q        <= vs_edge ? {11'd0, line_act} : (line_act ? inc12(vact_q) : vact_q);
            ha_q          <= line_act ? ac_q : (vs_edge ? 12'd0 : ha_q);
            sum_q         <= (vs_edge ? 24'd0 : sum_q) +
                             (act1_q ? 24'(r1_q) + 24'(g1_q) + 24'(b1_q) : 24'd0);
            out_valid_q   <= act1_q;
            out_x_q       <= act1_q ? ac_q : out_x_q;
            out_y_q       <= act1_q ? yc_q : out_y_q;
            out_r_q       <= act1_q ? r1_q : out_r_q;
            out_g_q       <= act1_q ? g1_q : out_g_q;
            out_b_q       <= act1_q ? b1_q : out_b_q;
            frame_start_q <= vs_edge;
            h_total_q     <= vs_edge ? line_len_q : h_total_q;
            h_active_q    <= vs_edge ? ha_q : h_active_q;
            v_total_q     <= vs_edge ? vt_q : v_total_q;
            v_active_q    <= vs_edge ? vact_q : v_active_q;
            frame_sum_q   <= vs_edge ? sum_q : frame_sum_q;
        end
    end

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mc_q    <= 4'd0;
            ref_q   <= 48'd0;
            te_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mc_q    <= mc_d;
            ref_q   <= ref_d;
            te_q    <= te_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mc_d    = mc_q;
        ref_d   = ref_q;
        te_d    = 1'b0;
        if (vs_edge) begin
            ref_d = meas;
            case (state_q)
                IDLE: begin
                    state_d = CHECK;
                    mc_d    = 4'd0;
                end
                CHECK: begin
                    mc_d    = match ? mc_q + 4'd1 : 4'd0;
                    state_d = (mc_d == 4'(LOCK_FRAMES)) ? LOCKED : CHECK;
                end
                default: begin
                    state_d = match ? LOCKED : CHECK;
                    mc_d    = match ? mc_q : 4'd0;
                    te_d    = !match;
                end
            endcase
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_x       = out_x_q;
    assign bus.out_y       = out_y_q;
    assign bus.out_R       = out_r_q;
    assign bus.out_G       = out_g_q;
    assign bus.out_B       = out_b_q;
    assign bus.frame_start = frame_start_q;
    assign bus.h_total     = h_total_q;
    assign bus.h_active    = h_active_q;
    assign bus.v_total     = v_total_q;
    assign bus.v_active    = v_active_q;
    assign bus.frame_sum   = frame_sum_q;
    assign bus.locked      = (state_q == LOCKED);
    assign bus.timing_err  = te_q;
endmodule
